// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Channel index width; a single channel still needs one select bit.
    function automatic int sel_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Pointer value after reset: the last channel, so the search starts at channel 0.
    function automatic int rst_ptr_f(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... (mod N_CH)
// and returns the first requesting channel.
module rr_arbiter #(
    parameter int N_CH  = 8,
    parameter int SEL_W = 3
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_idx
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = ptr;
        for (int i = 0; i < N_CH; i++) begin
            idx = (idx == SEL_W'(N_CH - 1)) ? '0 : idx + SEL_W'(1);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N_CH:1 packet-aware stream multiplexer with round-robin or fixed selection
// and a registered output stage.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int WIDTH = 8,
    localparam int SEL_W = sel_w_f(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  sel_mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_ch,
    input  logic                  out_ready,
    output state_t                state_dbg
);

    // Handshake: a beat moves on any interface only in a cycle where valid and
    // ready are both high at the rising edge; valid never waits on ready.

    localparam logic [SEL_W-1:0] RST_PTR = SEL_W'(rst_ptr_f(N_CH));

    state_t           state, state_nxt;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] lock_ch;
    logic             load_en;
    logic             arb_vld;
    logic [SEL_W-1:0] arb_idx;
    logic             sel_vld;
    logic             grant_vld;
    logic [SEL_W-1:0] grant;
    logic             beat_vld;
    logic             beat_last;
    logic [WIDTH-1:0] beat_data;
    logic             xfer;

    assign load_en   = !out_valid || out_ready;
    assign state_dbg = state;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req         (in_valid),
        .ptr         (rr_ptr),
        .grant_valid (arb_vld),
        .grant_idx   (arb_idx)
    );

    always_comb begin
        sel_vld   = 1'b0;
        grant     = '0;
        grant_vld = 1'b0;
        beat_vld  = 1'b0;
        beat_last = 1'b0;
        beat_data = '0;
        state_nxt = state;
        in_ready  = '0;

        // An out-of-range sel matches no channel, so it simply never grants.
        for (int c = 0; c < N_CH; c++) begin
            if (sel == SEL_W'(c)) sel_vld = in_valid[c];
        end

        case (state)
            IDLE: begin
                if (sel_mode) begin
                    grant     = sel;
                    grant_vld = sel_vld;
                end else begin
                    grant     = arb_idx;
                    grant_vld = arb_vld;
                end
            end
            LOCKED: grant = lock_ch;
            default: grant = '0;
        endcase

        for (int c = 0; c < N_CH; c++) begin
            if (grant == SEL_W'(c)) begin
                beat_vld  = in_valid[c];
                beat_last = in_last[c];
                beat_data = in_data[c*WIDTH +: WIDTH];
            end
        end
        if (state == LOCKED) grant_vld = beat_vld;

        // A locked channel sees ready whenever the output can load, valid or not.
        if (!rst && load_en && (grant_vld || state == LOCKED)) begin
            for (int c = 0; c < N_CH; c++) begin
                if (grant == SEL_W'(c)) in_ready[c] = 1'b1;
            end
        end

        xfer = grant_vld && load_en && !rst;
        if (xfer) state_nxt = beat_last ? IDLE : LOCKED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= RST_PTR;
            lock_ch   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else begin
            state <= state_nxt;
            if (load_en) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= beat_data;
                    out_last <= beat_last;
                    out_ch   <= grant;
                end
            end
            if (xfer) begin
                if (beat_last) rr_ptr  <= grant;
                else           lock_ch <= grant;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: driver pushes expected output beats,
// a negedge monitor pops and compares them as the DUT hands them downstream.
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    // ---------------- clock / reset / signals ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [7:0]  in_valid, in_last, in_ready;
    logic        sel_mode;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid, out_last, out_ready;
    logic [2:0]  out_ch;
    state_t      state_dbg;

    // small 5-channel instance for the out-of-range select case
    logic [39:0] in_data2 = '0;
    logic [4:0]  in_valid2 = 5'h1F, in_last2 = 5'h1F, in_ready2;
    logic        sel_mode2 = 1'b1, out_ready2 = 1'b1;
    logic [2:0]  sel2 = 3'd6;
    logic [7:0]  out_data2;
    logic        out_valid2, out_last2;
    logic [2:0]  out_ch2;
    state_t      state_dbg2;

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(8), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .sel_mode(sel_mode), .sel(sel),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_ch(out_ch), .out_ready(out_ready), .state_dbg(state_dbg)
    );

    stream_mux_rr #(.N_CH(5), .WIDTH(8)) dut5 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
        .in_last(in_last2), .in_ready(in_ready2), .sel_mode(sel_mode2), .sel(sel2),
        .out_data(out_data2), .out_valid(out_valid2), .out_last(out_last2),
        .out_ch(out_ch2), .out_ready(out_ready2), .state_dbg(state_dbg2)
    );

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];   // {last, ch, data}
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_beat: got %0h, expected none", {out_last, out_ch, out_data});
            end else begin
                chk("out_beat", 32'({out_last, out_ch, out_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_d(input int ch, input logic [7:0] val);
        in_data[ch*8 +: 8] = val;
    endtask

    // One cycle: drive, check ready/valid mid-cycle, record expected beat, advance.
    task automatic step(input logic [7:0] v, input logic [7:0] l, input logic ordy,
                        input logic [7:0] exp_rdy, input logic exp_ov, input string name);
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        @(negedge clk);
        chk({name, "/in_ready"}, 32'(in_ready), 32'(exp_rdy));
        chk({name, "/out_valid"}, 32'(out_valid), 32'(exp_ov));
        for (int c = 0; c < 8; c++) begin
            if (exp_rdy[c] && v[c]) exp_q.push_back({l[c], 3'(c), in_data[c*8 +: 8]});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; in_valid = 8'hFF; in_last = 8'hFF; out_ready = 1'b1;
        sel_mode = 1'b0; sel = 3'd0;
        for (int c = 0; c < 8; c++) in_data[c*8 +: 8] = 8'h40 + 8'(c);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst/in_ready", 32'(in_ready), 32'h0);
        chk("rst/out_valid", 32'(out_valid), 32'h0);
        chk("rst/out_data", 32'(out_data), 32'h0);
        chk("rst/out_last", 32'(out_last), 32'h0);
        chk("rst/out_ch", 32'(out_ch), 32'h0);
        chk("rst/state", 32'(state_dbg), 32'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: round robin between ch0 and ch2
        step(8'h05, 8'hFF, 1'b1, 8'h01, 1'b0, "rr0");
        step(8'h05, 8'hFF, 1'b1, 8'h04, 1'b1, "rr2");
        step(8'h05, 8'hFF, 1'b1, 8'h01, 1'b1, "rr0b");
        step(8'h05, 8'hFF, 1'b1, 8'h04, 1'b1, "rr2b");
        step(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, "rr_drain");
        step(8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, "rr_clear");

        // 2: ch3 4-beat packet holds off ch1
        set_d(3, 8'h10); step(8'h0A, 8'h02, 1'b1, 8'h08, 1'b0, "pkt_b1");
        set_d(3, 8'h11); step(8'h0A, 8'h02, 1'b1, 8'h08, 1'b1, "pkt_b2");
        chk("pkt/state", 32'(state_dbg), 32'(LOCKED));
        set_d(3, 8'h12); step(8'h0A, 8'h02, 1'b1, 8'h08, 1'b1, "pkt_b3");
        set_d(3, 8'h13); step(8'h0A, 8'h0A, 1'b1, 8'h08, 1'b1, "pkt_b4");
        step(8'h02, 8'h02, 1'b1, 8'h02, 1'b1, "pkt_ch1");
        step(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, "pkt_drain");

        // 3: fixed select
        sel_mode = 1'b1; sel = 3'd5;
        step(8'hFF, 8'hFF, 1'b1, 8'h20, 1'b0, "fix5");
        step(8'hDF, 8'hFF, 1'b1, 8'h00, 1'b1, "fix5_novalid");
        step(8'hDF, 8'hFF, 1'b1, 8'h00, 1'b0, "fix5_fall");
        chk("n5/sel6_ready", 32'(in_ready2), 32'h0);
        sel2 = 3'd4;
        #1;
        chk("n5/sel4_ready", 32'(in_ready2), 32'h10);
        sel2 = 3'd6;

        // 4: output hold under backpressure
        sel_mode = 1'b0;
        set_d(0, 8'hAA); step(8'h01, 8'h01, 1'b1, 8'h01, 1'b0, "hold_load");
        set_d(0, 8'hBB);
        for (int i = 0; i < 3; i++) begin
            step(8'h01, 8'h01, 1'b0, 8'h00, 1'b1, "hold");
            chk("hold/out_data", 32'(out_data), 32'hAA);
            chk("hold/out_ch", 32'(out_ch), 32'h0);
        end
        step(8'h01, 8'h01, 1'b1, 8'h01, 1'b1, "hold_release");
        step(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, "hold_drain");
        step(8'h00, 8'h00, 1'b1, 8'h00, 1'b0, "hold_clear");
        set_d(0, 8'h40);

        // 5: mode change while ch6 is locked
        set_d(6, 8'h60); step(8'h40, 8'h00, 1'b1, 8'h40, 1'b0, "lk_b1");
        sel_mode = 1'b1; sel = 3'd2;
        step(8'h04, 8'h04, 1'b1, 8'h40, 1'b1, "lk_stall");
        set_d(6, 8'h61); step(8'h44, 8'h04, 1'b1, 8'h40, 1'b0, "lk_b2");
        set_d(6, 8'h62); step(8'h44, 8'h44, 1'b1, 8'h40, 1'b1, "lk_b3");
        step(8'h44, 8'h44, 1'b1, 8'h04, 1'b1, "lk_ch2");
        step(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, "lk_drain");

        // 6: reset while locked with a beat in flight
        sel_mode = 1'b0;
        set_d(4, 8'h70); step(8'h10, 8'h00, 1'b1, 8'h10, 1'b0, "rl_b1");
        rst = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        chk("rl/in_ready_rst", 32'(in_ready), 32'h0);
        chk("rl/out_valid_pre", 32'(out_valid), 32'h1);
        chk("rl/state_pre", 32'(state_dbg), 32'(LOCKED));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rl/out_valid", 32'(out_valid), 32'h0);
        chk("rl/in_ready", 32'(in_ready), 32'h0);
        chk("rl/state", 32'(state_dbg), 32'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());   // the in-flight ch4 beat is discarded by reset
        step(8'h05, 8'hFF, 1'b1, 8'h01, 1'b0, "rl_rr0");
        step(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, "rl_drain");
        step(8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, "rl_clear");

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
